// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
//   Bundles the parallel-word handshake and the serial-side outputs of
//   piso_serializer.
//
//   Handshake: a word transfers on a rising clk edge where pi_valid and
//   pi_ready are both 1. Upstream raises pi_valid with pi_data and holds both
//   until that edge; pi_ready never depends on pi_valid, and pi_data is only
//   sampled on the transfer edge.
//
//   Signals
//     pi_data   [WIDTH]  parallel word (upstream -> serializer)
//     pi_valid           upstream has a word
//     pi_ready           serializer takes a word this cycle
//     so                 serial data bit
//     so_en              so carries a valid data bit
//     sof / eof          first / last bit of a word
//     busy               serializer is in SHIFT or GAP
//     dbg_state  [2]     FSM state (0 IDLE, 1 SHIFT, 2 GAP) for observation
//
//   Modports: master = upstream/observer side, slave = serializer side.
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] pi_data;
   logic             pi_valid;
   logic             pi_ready;
   logic             so;
   logic             so_en;
   logic             sof;
   logic             eof;
   logic             busy;
   logic [1:0]       dbg_state;

   modport master (
      output pi_data, pi_valid,
      input  pi_ready, so, so_en, sof, eof, busy, dbg_state
   );

   modport slave (
      input  pi_data, pi_valid,
      output pi_ready, so, so_en, sof, eof, busy, dbg_state
   );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in serial-out serializer feeding the 4-bit SIPO shift register.
//   Takes a WIDTH-bit word over a valid/ready handshake and shifts it out one
//   bit per clk, MSB first (or LSB first when LSB_FIRST=1), with sof/eof frame
//   markers and an optional GAP-cycle idle gap after each word.
//
//   Ports
//     clk   rising-edge clock
//     clr   asynchronous active-low reset (0 = reset)
//     bus   piso_serializer_if.slave: pi_data/pi_valid in, pi_ready, so,
//           so_en, sof, eof, busy and dbg_state out
//
//   Parameters
//     WIDTH      word width, 2..16
//     LSB_FIRST  0: MSB first, 1: LSB first
//     GAP        idle cycles forced after each word, 0..15
// ---------------------------------------------------------------------------
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 0,
   parameter int GAP       = 0
) (
   input logic              clk,
   input logic              clr,
   piso_serializer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WIDTH - 1);
   // GAP cycles are counted GAP-1 down to 0; unused when GAP=0.
   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [3:0]       bit_cnt;
   logic [3:0]       gap_cnt;

   logic             ready;
   logic             accept;
   logic             last_bit;
   logic             so_en_c;
   logic             so_c;
   logic             sof_c;
   logic             busy_c;

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (last_bit) begin
               if (GAP > 0)     state_nxt = ST_GAP;
               else if (accept) state_nxt = ST_SHIFT;  // back-to-back reload
               else             state_nxt = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt == 4'd0) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output logic. Outputs decode from registered state/shift register, so a
   // reset clears them at once without waiting for clk.
   always_comb begin
      so_en_c  = (state == ST_SHIFT);
      last_bit = so_en_c && (bit_cnt == 4'd0);
      sof_c    = so_en_c && (bit_cnt == CNT_LOAD);
      busy_c   = (state != ST_IDLE);
      so_c     = 1'b0;
      if (so_en_c) begin
         so_c = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
      end
      // With no gap the next word may load during the eof cycle.
      ready    = (state == ST_IDLE) || (last_bit && (GAP == 0));
      accept   = bus.pi_valid && ready;
   end

   // Datapath: shift register, bit counter and gap counter
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         shreg   <= '0;
         bit_cnt <= 4'd0;
         gap_cnt <= 4'd0;
      end else begin
         if (accept) begin
            shreg   <= bus.pi_data;
            bit_cnt <= CNT_LOAD;
         end else if (so_en_c && !last_bit) begin
            shreg   <= (LSB_FIRST != 0) ? {1'b0, shreg[WIDTH-1:1]}
                                        : {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
         end

         if (last_bit) begin
            gap_cnt <= GAP_LOAD;
         end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

   assign bus.pi_ready  = ready;
   assign bus.so        = so_c;
   assign bus.so_en     = so_en_c;
   assign bus.sof       = sof_c;
   assign bus.eof       = last_bit;
   assign bus.busy      = busy_c;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Six serializer lanes with different WIDTH / LSB_FIRST / GAP settings share
//   clk and clr. Each lane has a schedule model: an accepted word appends one
//   record per future output cycle (WIDTH bit cycles, then GAP idle cycles) to
//   exp_q; the lane is ready when the schedule is empty, or, with GAP=0, when
//   the current cycle is the word's last bit. A per-lane compare process
//   checks every cycle on the falling edge. Directed sequences with literal
//   expectations come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

   localparam int NL = 6;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   // ---------------- stimulus storage ----------------
   logic        pi_valid_a [NL];
   logic [15:0] pi_data_a  [NL];

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- lanes: DUT + model + compare ----------------
   for (genvar g = 0; g < NL; g++) begin : lane
      localparam int W = (g == 4) ? 2 : (g == 5) ? 16 : 4;
      localparam int L = (g == 1 || g == 4) ? 1 : 0;
      localparam int G = (g == 2) ? 2 : (g == 3) ? 3 : (g == 5) ? 15 : 0;

      piso_serializer_if #(.WIDTH(W)) bus ();

      assign bus.pi_valid = pi_valid_a[g];
      assign bus.pi_data  = pi_data_a[g][W-1:0];

      piso_serializer #(.WIDTH(W), .LSB_FIRST(L), .GAP(G)) dut (
         .clk (clk),
         .clr (clr),
         .bus (bus.slave)
      );

      // record = {so, so_en, sof, eof, busy}
      logic [4:0] exp_q[$];

      always @(negedge clk) begin : compare
         logic [4:0] cur;
         logic       rdy;
         logic [5:0] act;
         logic       b;
         act = {bus.so, bus.so_en, bus.sof, bus.eof, bus.busy, bus.pi_ready};
         if (!clr) begin
            exp_q.delete();
            vectors++;
            if (act !== 6'b000001) begin
               miscompares++;
               $display("FAIL lane%0d reset_outputs: got %b expected %b", g, act, 6'b000001);
            end
         end else begin
            cur = (exp_q.size() != 0) ? exp_q[0] : 5'b00000;
            rdy = (exp_q.size() == 0) || ((G == 0) && cur[1]);
            vectors++;
            if (act !== {cur, rdy}) begin
               miscompares++;
               $display("FAIL lane%0d outputs {so,so_en,sof,eof,busy,ready} at %0t: got %b expected %b",
                        g, $time, act, {cur, rdy});
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (bus.pi_valid && rdy) begin
               for (int i = 0; i < W; i++) begin
                  b = (L != 0) ? bus.pi_data[i] : bus.pi_data[W-1-i];
                  exp_q.push_back({b, 1'b1, (i == 0), (i == W - 1), 1'b1});
               end
               for (int i = 0; i < G; i++) exp_q.push_back(5'b00001);
            end
         end
      end
   end

   // ---------------- driver / literal-check tasks ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   // Literal expectations, bit c = cycle c after the first accept edge.
   logic [9:1] l0_so, l0_en, l0_sof, l0_eof, l0_rdy;
   logic [9:1] l1_so, l2_en, l2_busy, l2_rdy, l2_sof;
   logic [4:1] r_so, r_sof;

   initial begin
      l0_so   = 9'b001100101;  // 1010 then 0110, MSB first
      l0_en   = 9'b011111111;
      l0_sof  = 9'b000010001;
      l0_eof  = 9'b010001000;
      l0_rdy  = 9'b110001000;
      l1_so   = 9'b000000011;  // 0011 LSB first: 1,1,0,0
      l2_en   = 9'b110001111;
      l2_busy = 9'b110111111;
      l2_rdy  = 9'b001000000;
      l2_sof  = 9'b010000001;
      r_so    = 4'b1010;       // 0101 MSB first: 0,1,0,1 (bit1 = cycle 1)
      r_sof   = 4'b0001;

      clr = 1'b0;
      for (int k = 0; k < NL; k++) begin
         pi_valid_a[k] = 1'b0;
         pi_data_a[k]  = 16'h0;
      end
      #1;
      chk("reset_ready", 32'(lane[0].bus.pi_ready), 32'd1);
      chk("reset_busy", 32'(lane[0].bus.busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 clr = 1'b1;

      // Directed: lane0 back-to-back, lane1 LSB-first, lane2 gap of 2.
      next_cycle();
      pi_valid_a[0] = 1'b1; pi_data_a[0] = 16'hA;
      pi_valid_a[1] = 1'b1; pi_data_a[1] = 16'h3;
      pi_valid_a[2] = 1'b1; pi_data_a[2] = 16'hA;
      for (int c = 1; c <= 9; c++) begin
         next_cycle();
         if (c == 1) pi_valid_a[1] = 1'b0;
         if (c == 4) pi_data_a[0] = 16'h6;
         if (c == 5) pi_valid_a[0] = 1'b0;
         @(negedge clk);
         chk($sformatf("b2b_so_c%0d", c), 32'(lane[0].bus.so), 32'(l0_so[c]));
         chk($sformatf("b2b_so_en_c%0d", c), 32'(lane[0].bus.so_en), 32'(l0_en[c]));
         chk($sformatf("b2b_sof_c%0d", c), 32'(lane[0].bus.sof), 32'(l0_sof[c]));
         chk($sformatf("b2b_eof_c%0d", c), 32'(lane[0].bus.eof), 32'(l0_eof[c]));
         chk($sformatf("b2b_ready_c%0d", c), 32'(lane[0].bus.pi_ready), 32'(l0_rdy[c]));
         if (c <= 4) chk($sformatf("lsb_so_c%0d", c), 32'(lane[1].bus.so), 32'(l1_so[c]));
         chk($sformatf("gap_so_en_c%0d", c), 32'(lane[2].bus.so_en), 32'(l2_en[c]));
         chk($sformatf("gap_busy_c%0d", c), 32'(lane[2].bus.busy), 32'(l2_busy[c]));
         chk($sformatf("gap_ready_c%0d", c), 32'(lane[2].bus.pi_ready), 32'(l2_rdy[c]));
         chk($sformatf("gap_sof_c%0d", c), 32'(lane[2].bus.sof), 32'(l2_sof[c]));
      end
      pi_valid_a[2] = 1'b0;
      repeat (8) next_cycle();

      // Directed: reset in the middle of 1111 on lane0, then a fresh word.
      pi_valid_a[0] = 1'b1; pi_data_a[0] = 16'hF;
      next_cycle();                    // cycle 1 (bit 1)
      pi_valid_a[0] = 1'b0;
      next_cycle();                    // cycle 2 (bit 2)
      @(posedge clk);                  // cycle 3 begins
      #3 clr = 1'b0;
      #1;
      chk("midreset_so", 32'(lane[0].bus.so), 32'd0);
      chk("midreset_so_en", 32'(lane[0].bus.so_en), 32'd0);
      chk("midreset_busy", 32'(lane[0].bus.busy), 32'd0);
      chk("midreset_ready", 32'(lane[0].bus.pi_ready), 32'd1);
      next_cycle();
      clr = 1'b1;
      pi_valid_a[0] = 1'b1; pi_data_a[0] = 16'h5;
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         if (c == 1) pi_valid_a[0] = 1'b0;
         @(negedge clk);
         chk($sformatf("after_reset_so_c%0d", c), 32'(lane[0].bus.so), 32'(r_so[c]));
         chk($sformatf("after_reset_sof_c%0d", c), 32'(lane[0].bus.sof), 32'(r_sof[c]));
      end
      repeat (4) next_cycle();

      // Randomized traffic: pi_data churns every cycle, including while the
      // lane is not ready, so only the word present on an accept edge counts.
      for (int n = 0; n < 4000; n++) begin
         next_cycle();
         for (int k = 0; k < NL; k++) begin
            pi_valid_a[k] = ($urandom_range(0, 3) != 0);
            pi_data_a[k]  = 16'($urandom);
         end
         if (n == 2500) begin
            #2 clr = 1'b0;
            next_cycle();
            clr = 1'b1;
         end
      end
      for (int k = 0; k < NL; k++) pi_valid_a[k] = 1'b0;
      repeat (40) next_cycle();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out serializer sitting directly upstream of the team's 4-bit SIPO shift register; drives that block's serial input.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clk.
- Provides per-bit qualifier and frame markers so the downstream stage can tell when a full word has been delivered.
- Optional idle gap between consecutive words.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..16.
- LSB_FIRST, 0, bit order: 0 shifts the MSB first, 1 shifts the LSB first.
- GAP, 0, forced idle cycles after each word; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-low reset (0 = reset)
- pi_data  input  WIDTH  parallel word; sampled only on an accept edge
- pi_valid  input  1  upstream has a word
- pi_ready  output  1  serializer can take a word this cycle
- so  output  1  serial data, registered
- so_en  output  1  high while so carries a valid data bit
- sof  output  1  high during the first bit of a word
- eof  output  1  high during the last bit of a word
- busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; shift register, bit counter and gap counter cleared; so=0, so_en=0, sof=0, eof=0, busy=0, pi_ready=1 (combinational from IDLE). pi_valid and pi_data ignored while clr=0.
- States: IDLE, SHIFT, GAP.
- Accept: pi_valid=1 and pi_ready=1 at a rising clk edge. pi_data is loaded into the shift register and the bit counter is set to WIDTH-1.
- pi_ready is 1 in IDLE. It is also 1 in SHIFT during the eof cycle when GAP=0. It is 0 otherwise.
- IDLE: on accept, go to SHIFT. Without accept, remain in IDLE with so=0 and so_en=0.
- Latency: the first bit is on so in the cycle after the accept edge.
- SHIFT:
  - Each cycle presents one bit, with so_en=1.
  - Bit order: MSB down to LSB, or LSB up to MSB when LSB_FIRST=1.
  - sof=1 when counter=WIDTH-1; eof=1 when counter=0. With WIDTH>=2, sof and eof are never high together.
  - The counter decrements every cycle. At counter=0:
    - GAP>0: go to GAP.
    - GAP=0 with accept in the same cycle: reload and stay in SHIFT. This gives a back-to-back stream with no bubble; the next word's sof follows the current eof directly.
    - GAP=0 without accept: go to IDLE.
- GAP: so=0, so_en=0, pi_ready=0 for exactly GAP cycles, then IDLE.
- Throughput: one word per WIDTH cycles (GAP=0), or per WIDTH+GAP+1 cycles (GAP>0).
- pi_valid held high while pi_ready=0: no accept, no state change. Upstream must hold pi_data stable until accepted.
- pi_data changing after accept: no effect on the word in flight.
- clr asserted mid-word: all outputs go to reset values immediately. The partial word is discarded and is not resumed. After release, the next accept starts a fresh word with sof.
- busy = (state != IDLE).

Test Plan:
- WIDTH=4, LSB_FIRST=0, GAP=0; accept 4'b1010 -> so=1,0,1,0 on the next 4 cycles; so_en=1 throughout; sof on bit 1; eof on bit 4; then so_en=0 and pi_ready=1.
- Back-to-back: pi_valid held with 4'b1010, then 4'b0110 presented during the eof cycle -> 8 contiguous so_en cycles carrying 1,0,1,0,0,1,1,0; sof at cycles 1 and 5; eof at cycles 4 and 8.
- LSB_FIRST=1, accept 4'b0011 -> so=1,1,0,0.
- GAP=2: two words offered continuously -> after eof, exactly 2 cycles with so_en=0, busy=1, pi_ready=0; then 1 IDLE cycle with pi_ready=1; next word's sof follows.
- Reset: drop clr to 0 after bit 2 of 4'b1111 -> so, so_en, busy go to 0 without waiting for clk. After release, accept 4'b0101 -> so=0,1,0,1 with sof on the first bit.
- Hold-off: pi_valid=1 continuously with GAP=3 -> pi_data changes while pi_ready=0 are not captured; exactly one accept per word period.
